// File: rtl/dac_sample_sequencer_if.sv
// rtl/dac_sample_sequencer_if.sv - sample stream and DAC controller handshake bundle
interface dac_sample_sequencer_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] ch_value;
  logic        enable;
  logic        busy;

  // master is the environment: upstream sample source plus the DAC controller
  modport master (output s_data, s_valid, busy, input s_ready, ch_value, enable);
  modport slave  (input s_data, s_valid, busy, output s_ready, ch_value, enable);
endinterface

// File: rtl/dac_sample_sequencer.sv
// rtl/dac_sample_sequencer.sv - paces buffered DAC codes into the DAC write controller
module dac_sample_sequencer #(
  parameter int DEPTH = 16,
  parameter int LVL_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [15:0]          rate_div,
  input  logic                 flush,
  input  logic                 clr_stats,
  dac_sample_sequencer_if.slave bus,
  output logic [LVL_W-1:0]     fifo_level,
  output logic [15:0]          underrun_cnt,
  output logic [15:0]          late_cnt
);
  localparam int AW = LVL_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

  state_t           state;
  state_t           state_next;
  logic             req_en;
  logic [15:0]      div_cnt;
  logic             tick;
  logic [15:0]      mem [DEPTH];
  logic [LVL_W-1:0] wr_ptr;
  logic [LVL_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             underrun_hit;
  logic             late_hit;
  logic [15:0]      ch_q;

  // A rate_div lowered below div_cnt lets the counter run round through 0xFFFF.
  assign tick = run && (div_cnt == rate_div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (!run || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign fifo_level  = wr_ptr - rd_ptr;
  assign full        = (fifo_level == LVL_W'(DEPTH));
  assign empty       = (fifo_level == '0);
  assign bus.s_ready = !full;
  assign push        = bus.s_valid && !full && !flush;
  assign pop         = (state == S_IDLE) && tick && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= bus.s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      ch_q  <= '0;
    end else begin
      state <= state_next;
      if (pop) ch_q <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_comb begin
    state_next = state;
    req_en     = 1'b0;
    case (state)
      S_IDLE: if (pop) state_next = S_REQ;
      S_REQ: begin
        req_en = 1'b1;
        if (bus.busy) state_next = S_XFER;
      end
      S_XFER: if (!bus.busy) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // enable decodes straight from state so an async reset drops it at once.
  assign bus.enable   = req_en;
  assign bus.ch_value = ch_q;

  assign underrun_hit = (state == S_IDLE) && tick && empty;
  assign late_hit     = (state != S_IDLE) && tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun_cnt <= '0;
      late_cnt     <= '0;
    end else if (clr_stats) begin
      underrun_cnt <= '0;
      late_cnt     <= '0;
    end else begin
      if (underrun_hit && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
      if (late_hit && late_cnt != 16'hFFFF)         late_cnt     <= late_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_dac_sample_sequencer.sv
// tb/tb_dac_sample_sequencer.sv - directed and randomized checks of dac_sample_sequencer
module tb_dac_sample_sequencer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        flush = 1'b0;
  logic        clr_stats = 1'b0;
  logic [15:0] rate_div = 16'd0;
  logic [4:0]  fifo_level;
  logic [15:0] underrun_cnt;
  logic [15:0] late_cnt;

  dac_sample_sequencer_if bus ();

  dac_sample_sequencer #(.DEPTH(DEPTH), .LVL_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .rate_div     (rate_div),
    .flush        (flush),
    .clr_stats    (clr_stats),
    .bus          (bus.slave),
    .fifo_level   (fifo_level),
    .underrun_cnt (underrun_cnt),
    .late_cnt     (late_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] q[$];
  logic [15:0] m_ch;
  bit          m_req;
  bit          m_xfer;
  int          m_under;
  int          m_late;
  int          run_age;

  int          hold = 20;
  int          req_age;
  int          busy_left;
  bit          en_seen;
  bit          prev_en;
  logic [15:0] seen[$];
  logic [15:0] vals[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ch      = '0;
    m_req     = 1'b0;
    m_xfer    = 1'b0;
    m_under   = 0;
    m_late    = 0;
    run_age   = 0;
    req_age   = 0;
    busy_left = 0;
    bus.busy  = 1'b0;
  endtask

  // DAC controller: busy rises 2 cycles after enable and stays up for 'hold' cycles.
  task automatic drive_busy();
    if (busy_left > 0) begin
      bus.busy = 1'b1;
      busy_left--;
    end else if (m_req) begin
      if (req_age >= 2) begin
        bus.busy  = 1'b1;
        busy_left = hold - 1;
      end else begin
        bus.busy = 1'b0;
      end
      req_age++;
    end else begin
      bus.busy = 1'b0;
      req_age  = 0;
    end
  endtask

  // Reference: ticks fall every rate_div+1 cycles counted from when run rose.
  task automatic model_update();
    bit tick;
    bit idle;
    bit accept;
    int sz;
    sz     = q.size();
    idle   = !m_req && !m_xfer;
    tick   = run && ((run_age % (int'(rate_div) + 1)) == int'(rate_div));
    run_age = run ? run_age + 1 : 0;
    accept = bus.s_valid && (sz < DEPTH);
    if (tick && idle && sz > 0) begin
      m_ch  = q.pop_front();
      m_req = 1'b1;
    end else if (m_req && bus.busy) begin
      m_req  = 1'b0;
      m_xfer = 1'b1;
    end else if (m_xfer && !bus.busy) begin
      m_xfer = 1'b0;
    end
    if (flush) q.delete();
    else if (accept) q.push_back(bus.s_data);
    if (clr_stats) begin
      m_under = 0;
      m_late  = 0;
    end else begin
      if (tick && idle && sz == 0 && m_under < 65535) m_under++;
      if (tick && !idle && m_late < 65535) m_late++;
    end
  endtask

  task automatic check_all();
    chk("enable", bus.enable, m_req);
    chk("ch_value", bus.ch_value, m_ch);
    chk("fifo_level", fifo_level, q.size());
    chk("s_ready", bus.s_ready, q.size() < DEPTH);
    chk("underrun_cnt", underrun_cnt, m_under);
    chk("late_cnt", late_cnt, m_late);
  endtask

  task automatic step();
    drive_busy();
    model_update();
    @(posedge clk);
    #1;
    check_all();
    if (bus.enable) en_seen = 1'b1;
    if (bus.enable && !prev_en) seen.push_back(bus.ch_value);
    prev_en = bus.enable;
  endtask

  initial begin
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    model_reset();
    prev_en = 1'b0;
    vals[0] = 16'h1000;
    vals[1] = 16'h2000;
    vals[2] = 16'h3000;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    step();

    // paced playback
    for (int i = 0; i < 3; i++) begin
      bus.s_data  = vals[i];
      bus.s_valid = 1'b1;
      step();
    end
    bus.s_valid = 1'b0;
    hold     = 20;
    rate_div = 16'd99;
    seen.delete();
    run = 1'b1;
    repeat (310) step();
    run = 1'b0;
    repeat (30) step();
    chk("play_count", seen.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("play_code", (i < seen.size()) ? seen[i] : 16'hDEAD, vals[i]);
    chk("play_underrun", underrun_cnt, 0);
    chk("play_late", late_cnt, 0);

    // underrun with an empty FIFO
    rate_div = 16'd9;
    en_seen  = 1'b0;
    run = 1'b1;
    repeat (50) step();
    run = 1'b0;
    step();
    chk("underrun_total", underrun_cnt, 5);
    chk("underrun_no_enable", en_seen, 0);

    // late ticks with the FIFO kept full
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    bus.s_valid = 1'b1;
    repeat (16) begin
      bus.s_data = 16'($urandom);
      step();
    end
    rate_div = 16'd3;
    run = 1'b1;
    repeat (99) begin
      bus.s_data = 16'($urandom);
      step();
    end
    run = 1'b0;
    repeat (30) begin
      bus.s_data = 16'($urandom);
      step();
    end
    bus.s_valid = 1'b0;
    chk("late_total", late_cnt, 20);
    chk("late_level", fifo_level, 16);
    chk("late_underrun", underrun_cnt, 0);

    // FIFO full then flush
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.s_data  = 16'($urandom);
      bus.s_valid = 1'b1;
      step();
      if (i == 15) begin
        chk("full_ready", bus.s_ready, 0);
        chk("full_level", fifo_level, 16);
      end
    end
    chk("full_reject_level", fifo_level, 16);
    flush = 1'b1;
    step();
    chk("flush_level", fifo_level, 0);
    flush = 1'b0;
    bus.s_valid = 1'b0;
    step();

    // saturation and clear priority
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    rate_div = 16'd0;
    run = 1'b1;
    repeat (65540) step();
    chk("sat_hold", underrun_cnt, 16'hFFFF);
    clr_stats = 1'b1;
    step();
    chk("sat_clear_wins", underrun_cnt, 0);
    clr_stats = 1'b0;
    step();
    chk("sat_after_clear", underrun_cnt, 1);
    run = 1'b0;
    step();

    // reset during S_REQ
    bus.s_data  = 16'h5A5A;
    bus.s_valid = 1'b1;
    step();
    bus.s_valid = 1'b0;
    rate_div = 16'd2;
    run = 1'b1;
    for (int i = 0; i < 20 && !m_req; i++) step();
    chk("rst_in_req", bus.enable, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_enable_async", bus.enable, 0);
    chk("rst_level_async", fifo_level, 0);
    model_reset();
    run = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    chk("rst_ch_value", bus.ch_value, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_enable", bus.enable, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dac_sample_sequencer.md
# dac_sample_sequencer

Paces a stream of 16-bit DAC codes into the DAC write controller at a programmable sample rate. It sits directly upstream of that controller and drives its `ch_value`/`enable` inputs, watching its `busy` output. Incoming samples arrive over a valid/ready stream and are buffered in a small FIFO. Rate ticks that cannot be served are counted so firmware can detect underrun and over-rate conditions.

## Interface

**Parameters**
- `DEPTH`, default 16: FIFO depth in samples; must be a power of two, minimum 2.
- `LVL_W`, default 5: width of `fifo_level`; equals log2(`DEPTH`)+1.

**Ports**
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `run` input 1: tick generator enable.
- `rate_div` input 16: tick period minus one, in clk cycles.
- `flush` input 1: synchronous FIFO clear.
- `clr_stats` input 1: synchronous clear of both counters.
- `s_data` input 16: sample code from upstream.
- `s_valid` input 1: `s_data` is valid.
- `s_ready` output 1: FIFO can accept a sample; equals !full.
- `ch_value` output 16: code presented to the DAC controller.
- `enable` output 1: write request to the DAC controller.
- `busy` input 1: DAC controller is busy.
- `fifo_level` output `LVL_W`: number of samples currently stored.
- `underrun_cnt` output 16: ticks that found the FIFO empty; saturates at 0xFFFF.
- `late_cnt` output 16: ticks that arrived while a transfer was in flight; saturates at 0xFFFF.

## Operation

**Tick generator**
- 16-bit counter `div_cnt`.
- While `run`=0: `div_cnt` is held at 0 and no ticks are produced.
- While `run`=1: `tick` = (`div_cnt` == `rate_div`). On a tick, `div_cnt` returns to 0; otherwise it increments.
- `rate_div`=0 gives a tick every cycle.
- A change to `rate_div` takes effect immediately. If `div_cnt` > `rate_div`, the counter increments until it wraps past 0xFFFF and reaches `rate_div`; this is accepted behaviour.

**FIFO**
- `DEPTH` entries, with wrapping read and write pointers.
- Push when `s_valid` && `s_ready`.
- Pop happens only from the FSM, in S_IDLE on a tick.
- A simultaneous push and pop leaves the level unchanged.
- When full, `s_ready`=0 even if a pop occurs in the same cycle.
- `flush` empties the FIFO in the next cycle and overrides any push in that cycle. It does not affect `ch_value` or the FSM.

**FSM**
- **S_IDLE** (`enable`=0):
  - tick with FIFO non-empty: pop the head into `ch_value`, set `enable`=1, go to S_REQ.
  - tick with FIFO empty: `underrun_cnt`++, stay in S_IDLE.
- **S_REQ** (`enable`=1, `ch_value` stable): when `busy`=1, set `enable`=0 and go to S_XFER.
- **S_XFER** (`enable`=0): when `busy`=0, go to S_IDLE.
- A tick in S_REQ or S_XFER does `late_cnt`++. The tick is dropped and nothing is popped.
- `run` falling mid-transfer: the current transfer completes normally and no further ticks occur.
- `clr_stats` zeroes both counters. If an increment coincides with `clr_stats`, the clear wins.
- Counters hold at 0xFFFF and do not wrap.

## Timing

**Reset values**
- `ch_value`=0, `enable`=0, FSM in S_IDLE.
- `div_cnt`=0, FIFO empty, `fifo_level`=0.
- `underrun_cnt`=0, `late_cnt`=0.
- `s_ready`=1 (combinational from !full).

**Latencies**
- Tick in cycle T, in S_IDLE, FIFO non-empty: `ch_value` and `enable`=1 are visible at T+1, and `fifo_level` decrements at T+1.
- `busy`=1 sampled in cycle B during S_REQ: `enable`=0 at B+1.
- A push in cycle P: the sample is poppable by a tick at P+1 or later. There is no same-cycle bypass, so a tick at P with the FIFO empty counts as an underrun.
- Ticks are `rate_div`+1 cycles apart. The first tick after `run` rises comes `rate_div` cycles after `run` is first sampled high.

**Reset mid-operation**
- Asynchronous assertion forces all reset values immediately.
- `enable` drops in the same instant and any queued samples are lost.

## Test plan

- **Paced playback:** reset, push 0x1000, 0x2000, 0x3000; `rate_div`=99; `run`=1; DAC model raises `busy` 2 cycles after `enable` and holds it 20 cycles. Required: `ch_value` takes the three codes in order, one per 100 cycles; `underrun_cnt`=0 and `late_cnt`=0.
- **Underrun:** FIFO empty, `rate_div`=9, `run`=1 for 50 cycles. Required: `underrun_cnt`=5 and `enable` never asserts.
- **Late ticks:** `rate_div`=3 with `busy` held 20 cycles per transfer and the FIFO kept full. Required: `late_cnt` increments 5 times per transfer; each transfer pops exactly one sample.
- **FIFO full/flush:** push 17 samples with `DEPTH`=16 and `run`=0. Required:
  - `s_ready`=0 after the 16th push and the 17th sample is rejected; `fifo_level`=16.
  - Then `flush` together with `s_valid`=1: `fifo_level`=0 the next cycle.
- **Saturation and clear:** force `underrun_cnt` to 0xFFFF via an empty FIFO with `rate_div`=0. Required:
  - The counter holds at 0xFFFF.
  - `clr_stats` in the same cycle as an underrun tick gives 0 the next cycle.
- **Reset mid-transfer:** assert `rst`=0 during S_REQ. Required: `enable`=0 immediately; after release, `ch_value`=0, `fifo_level`=0, FSM in S_IDLE.
